// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus blocks (bus driver and the read/write
// sequencers that feed it).
//   rtc_state_t  : bus driver phase encoding
//   rtc_op_t     : kind of bus cycle latched at request time
//   DEF_T_*      : default phase lengths in clk cycles
//   CMD_XFER_F*  : RTC transfer command codes. To the bus driver these are
//                  ordinary write data.
//   phase_load() : value loaded into the 8-bit phase timer for a T-cycle phase
package rtc_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_HOLD = 3'd2,
    S_SETUP     = 3'd3,  // data setup for writes, bus turnaround for reads
    S_STROBE    = 3'd4,
    S_DATA_HOLD = 3'd5,
    S_DONE      = 3'd6,
    S_REC       = 3'd7
  } rtc_state_t;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } rtc_op_t;

  localparam int DEF_T_PULSE = 10;
  localparam int DEF_T_HOLD  = 2;
  localparam int DEF_T_SETUP = 2;
  localparam int DEF_T_REC   = 4;

  localparam logic [7:0] CMD_XFER_F0 = 8'hF0;
  localparam logic [7:0] CMD_XFER_F2 = 8'hF2;

  // A phase of T cycles counts T-1 down to 0 and leaves on the zero cycle.
  function automatic logic [7:0] phase_load(input int t);
    return 8'(t - 1);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 8-bit down-counter that times each bus phase.
//   clk, reset : system clock, synchronous active-high reset
//   load       : load `value` this edge (takes priority over counting)
//   value      : count to load
//   zero       : count has reached 0; the counter then stays at 0
module rtc_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] value,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= value;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/rtc_bus_driver.sv
// Physical bus stage for the RTC multiplexed address/data interface. Each
// accepted request becomes one timed bus cycle:
//   ADDR -> ADDR_HOLD -> SETUP(write)/TURN(read) -> STROBE -> DATA_HOLD -> DONE -> REC
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   escribe, activa     : write request and its grant qualifier
//   lee                 : read request
//   dir_in, dato_in     : register address / write data
//   ad_in               : AD pins, input side
//   fin                 : one-cycle completion pulse (reads and writes)
//   dato_leido          : last read data, held until the next read completes
//   cs_n, ad_n, rd_n, wr_n : active-low bus strobes
//   ad_out, ad_oe       : AD pins, output side and output enable
//   state_dbg           : current phase, for observation only
//
// Request/completion handshake: a request (escribe&&activa, or lee) is
// sampled only on an edge where the driver is idle -- in IDLE, or on the last
// REC edge, which returns to IDLE. That sampling edge is the acceptance point
// and has no separate acknowledge; requests on any other edge are ignored. A
// write beats a read when both are present. The requester holds its request
// until `fin` and must drop it within REC; `fin` is the only completion
// indication.
module rtc_bus_driver
  import rtc_pkg::*;
#(
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_REC   = DEF_T_REC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       escribe,
  input  logic       activa,
  input  logic [7:0] dir_in,
  input  logic [7:0] dato_in,
  input  logic       lee,
  input  logic [7:0] ad_in,
  output logic       fin,
  output logic [7:0] dato_leido,
  output logic       cs_n,
  output logic       ad_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output rtc_state_t state_dbg
);

  // Phase lengths must fit the 8-bit timer and must not be zero.
  if (T_PULSE < 1 || T_PULSE > 255) begin : g_bad_t_pulse
    $error("rtc_bus_driver: T_PULSE=%0d outside 1..255", T_PULSE);
  end
  if (T_HOLD < 1 || T_HOLD > 255) begin : g_bad_t_hold
    $error("rtc_bus_driver: T_HOLD=%0d outside 1..255", T_HOLD);
  end
  if (T_SETUP < 1 || T_SETUP > 255) begin : g_bad_t_setup
    $error("rtc_bus_driver: T_SETUP=%0d outside 1..255", T_SETUP);
  end
  // The write sequencer may leave a stale request up for 2 cycles after fin.
  if (T_REC < 3 || T_REC > 255) begin : g_bad_t_rec
    $error("rtc_bus_driver: T_REC=%0d outside 3..255", T_REC);
  end

  localparam logic [7:0] LD_PULSE = phase_load(T_PULSE);
  localparam logic [7:0] LD_HOLD  = phase_load(T_HOLD);
  localparam logic [7:0] LD_SETUP = phase_load(T_SETUP);
  localparam logic [7:0] LD_REC   = phase_load(T_REC);

  rtc_state_t state, state_nxt;
  rtc_op_t    op_q, op_nxt;
  logic [7:0] addr_q, addr_nxt;
  logic [7:0] data_q, data_nxt;

  logic       tmr_load;
  logic [7:0] tmr_value;
  logic       tmr_zero;
  logic       capture;
  logic       can_accept;

  logic       cs_n_d, ad_n_d, rd_n_d, wr_n_d, ad_oe_d, fin_d;
  logic [7:0] ad_out_d, dato_leido_d;

  rtc_phase_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  // Next state, phase timer control and request latching.
  always_comb begin
    state_nxt  = state;
    op_nxt     = op_q;
    addr_nxt   = addr_q;
    data_nxt   = data_q;
    tmr_load   = 1'b0;
    tmr_value  = 8'd0;
    capture    = 1'b0;
    can_accept = 1'b0;

    case (state)
      S_IDLE: can_accept = 1'b1;
      S_ADDR: if (tmr_zero) begin
        state_nxt = S_ADDR_HOLD;
        tmr_load  = 1'b1;
        tmr_value = LD_HOLD;
      end
      S_ADDR_HOLD: if (tmr_zero) begin
        state_nxt = S_SETUP;
        tmr_load  = 1'b1;
        tmr_value = LD_SETUP;
      end
      S_SETUP: if (tmr_zero) begin
        state_nxt = S_STROBE;
        tmr_load  = 1'b1;
        tmr_value = LD_PULSE;
      end
      S_STROBE: if (tmr_zero) begin
        state_nxt = S_DATA_HOLD;
        tmr_load  = 1'b1;
        tmr_value = LD_HOLD;
        // Read data is taken while RD# is still low.
        capture   = (op_q == OP_READ);
      end
      S_DATA_HOLD: if (tmr_zero) begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_REC;
        tmr_load  = 1'b1;
        tmr_value = LD_REC;
      end
      S_REC: if (tmr_zero) begin
        // The edge that re-enters IDLE may already take a new request.
        state_nxt  = S_IDLE;
        can_accept = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (can_accept) begin
      if (escribe && activa) begin
        state_nxt = S_ADDR;
        op_nxt    = OP_WRITE;
        addr_nxt  = dir_in;
        data_nxt  = dato_in;
        tmr_load  = 1'b1;
        tmr_value = LD_PULSE;
      end else if (lee) begin
        state_nxt = S_ADDR;
        op_nxt    = OP_READ;
        addr_nxt  = dir_in;
        tmr_load  = 1'b1;
        tmr_value = LD_PULSE;
      end
    end
  end

  // Bus values are decoded from the next state so that the pins change on
  // the same edge as the state: the accepting edge already drives ADDR.
  always_comb begin
    cs_n_d       = 1'b1;
    ad_n_d       = 1'b1;
    rd_n_d       = 1'b1;
    wr_n_d       = 1'b1;
    ad_oe_d      = 1'b0;
    ad_out_d     = 8'd0;
    fin_d        = 1'b0;
    dato_leido_d = capture ? ad_in : dato_leido;

    case (state_nxt)
      S_ADDR: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_nxt;
      end
      S_ADDR_HOLD: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_nxt;
      end
      S_SETUP, S_DATA_HOLD: begin
        cs_n_d = 1'b0;
        if (op_nxt == OP_WRITE) begin
          ad_oe_d  = 1'b1;
          ad_out_d = data_nxt;
        end
      end
      S_STROBE: begin
        cs_n_d = 1'b0;
        if (op_nxt == OP_WRITE) begin
          wr_n_d   = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = data_nxt;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      S_DONE:  fin_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= OP_WRITE;
      addr_q     <= 8'd0;
      data_q     <= 8'd0;
      cs_n       <= 1'b1;
      ad_n       <= 1'b1;
      rd_n       <= 1'b1;
      wr_n       <= 1'b1;
      ad_oe      <= 1'b0;
      ad_out     <= 8'd0;
      fin        <= 1'b0;
      dato_leido <= 8'd0;
    end else begin
      state      <= state_nxt;
      op_q       <= op_nxt;
      addr_q     <= addr_nxt;
      data_q     <= data_nxt;
      cs_n       <= cs_n_d;
      ad_n       <= ad_n_d;
      rd_n       <= rd_n_d;
      wr_n       <= wr_n_d;
      ad_oe      <= ad_oe_d;
      ad_out     <= ad_out_d;
      fin        <= fin_d;
      dato_leido <= dato_leido_d;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_rtc_bus_driver.sv
// Bench for rtc_bus_driver at default timing. Driver tasks issue requests
// and push the expected bus cycle; a negedge monitor rebuilds each bus cycle
// from the pins and checks it against the expected queue when fin pulses.
module tb_rtc_bus_driver;
  import rtc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       escribe = 1'b0, activa = 1'b0, lee = 1'b0;
  logic [7:0] dir_in = 8'd0, dato_in = 8'd0;
  logic [7:0] rd_val = 8'd0;
  logic [7:0] ad_in;
  logic       fin, cs_n, ad_n, rd_n, wr_n, ad_oe;
  logic [7:0] dato_leido, ad_out;
  rtc_state_t state_dbg;

  // Chip model: drives the read value only while RD# is low.
  assign ad_in = rd_n ? 8'hEE : rd_val;

  rtc_bus_driver dut (
    .clk        (clk),
    .reset      (reset),
    .escribe    (escribe),
    .activa     (activa),
    .dir_in     (dir_in),
    .dato_in    (dato_in),
    .lee        (lee),
    .ad_in      (ad_in),
    .fin        (fin),
    .dato_leido (dato_leido),
    .cs_n       (cs_n),
    .ad_n       (ad_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .ad_out     (ad_out),
    .ad_oe      (ad_oe),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic       is_wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] ad_len;
    logic [7:0] strb_len;
    logic [7:0] turn_len;
    logic [7:0] fin_lat;
    logic       flags;
  } xact_t;
  localparam int W = $bits(xact_t);
  logic [W-1:0] exp_q[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Every cycle at default timing: address and strobe low 10 cycles each,
  // fin 26 cycles after the first CS# low cycle, turnaround 2 for reads.
  task automatic push_exp(input logic wr, input logic [7:0] a, input logic [7:0] d);
    xact_t x;
    x.is_wr    = wr;
    x.addr     = a;
    x.data     = d;
    x.ad_len   = 8'd10;
    x.strb_len = 8'd10;
    x.turn_len = wr ? 8'd0 : 8'd2;
    x.fin_lat  = 8'd26;
    x.flags    = 1'b0;
    exp_q.push_back(x);
  endtask

  // ---------------- monitor ----------------
  bit         m_active = 0, m_addr_seen, m_data_seen, m_strb_seen, m_wr, m_flag;
  int         m_lat;
  logic [7:0] m_addr, m_data, m_adlen, m_strb, m_turn;
  xact_t      m_e;

  always @(negedge clk) begin
    if (reset) begin
      m_active = 0;
    end else begin
      if (!m_active && !cs_n) begin
        m_active = 1; m_lat = 0; m_addr_seen = 0; m_data_seen = 0;
        m_strb_seen = 0; m_wr = 0; m_flag = 0;
        m_adlen = 0; m_strb = 0; m_turn = 0; m_addr = 0; m_data = 0;
      end else if (m_active) begin
        m_lat++;
      end
      if (m_active) begin
        if (!ad_n) begin
          m_adlen++;
          if (!m_addr_seen) begin m_addr = ad_out; m_addr_seen = 1; end
          else if (ad_out !== m_addr) m_flag = 1;
          if (!ad_oe) m_flag = 1;
          if (!rd_n || !wr_n) m_flag = 1;  // address and data strobes overlap
        end
        if (!rd_n || !wr_n) begin
          m_strb++;
          m_strb_seen = 1;
          if (!wr_n) begin
            m_wr = 1;
            if (!m_data_seen) begin m_data = ad_out; m_data_seen = 1; end
            else if (ad_out !== m_data) m_flag = 1;
            if (!ad_oe) m_flag = 1;
          end
        end else if (!m_strb_seen && !cs_n && !ad_oe) begin
          m_turn++;
        end
        if (cs_n && !fin) m_flag = 1;  // CS# must stay low until DONE
        if (fin) begin
          m_active = 0;
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_fin: got bus cycle addr 0x%0h, expected none", m_addr);
          end else begin
            m_e = xact_t'(exp_q.pop_front());
            chk("cycle_is_write", 32'(m_wr), 32'(m_e.is_wr));
            chk("cycle_addr", 32'(m_addr), 32'(m_e.addr));
            chk("cycle_data", 32'(m_wr ? m_data : dato_leido), 32'(m_e.data));
            chk("ad_n_low_cycles", 32'(m_adlen), 32'(m_e.ad_len));
            chk("strobe_low_cycles", 32'(m_strb), 32'(m_e.strb_len));
            chk("turnaround_cycles", 32'(m_turn), 32'(m_e.turn_len));
            chk("fin_latency", 32'(m_lat), 32'(m_e.fin_lat));
            chk("bus_rule_violation", 32'(m_flag), 32'(m_e.flags));
          end
        end
      end else if (fin) begin
        n_vec++; n_bad++;
        $display("FAIL stray_fin: got fin=1 with no bus cycle, expected 0");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] d);
    escribe = wr; activa = wr; lee = rd; dir_in = a; dato_in = d;
  endtask

  task automatic release_req();
    escribe = 0; activa = 0; lee = 0;
  endtask

  // Returns at the negedge where fin is seen (or after the budget).
  task automatic wait_fin(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!fin && n < 60);
    chk(nm, 32'(fin), 32'd1);
  endtask

  // Full cycle: accept, wait for fin, sit out recovery.
  task automatic bus_cycle(input logic wr, input logic [7:0] a, input logic [7:0] d, input string nm);
    push_exp(wr, a, d);
    issue(wr, !wr, a, d);
    @(negedge clk);
    release_req();
    wait_fin(nm);
    repeat (5) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1;
    repeat (3) @(negedge clk);
    chk("reset_cs_n", 32'(cs_n), 32'd1);
    chk("reset_ad_n", 32'(ad_n), 32'd1);
    chk("reset_rd_n", 32'(rd_n), 32'd1);
    chk("reset_wr_n", 32'(wr_n), 32'd1);
    chk("reset_ad_oe", 32'(ad_oe), 32'd0);
    chk("reset_fin", 32'(fin), 32'd0);
    chk("reset_ad_out", 32'(ad_out), 32'd0);
    chk("reset_dato_leido", 32'(dato_leido), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'(S_IDLE));
    reset = 0;
    @(negedge clk);

    // Basic write and read.
    bus_cycle(1, 8'h21, 8'h59, "write_21_fin");
    rd_val = 8'h17;
    bus_cycle(0, 8'h24, 8'h17, "read_24_fin");
    chk("read_data_after_fin", 32'(dato_leido), 32'h17);

    // Write and read requested together: write first, read after recovery.
    rd_val = 8'h6C;
    push_exp(1, 8'h30, 8'hA5);
    push_exp(0, 8'h30, 8'h6C);
    issue(1, 1, 8'h30, 8'hA5);
    @(negedge clk);
    escribe = 0; activa = 0;
    wait_fin("both_write_fin");
    n = 0;
    do begin @(negedge clk); n++; end while (cs_n && n < 20);
    chk("both_read_start_after_fin", 32'(n), 32'd5);
    lee = 0;
    wait_fin("both_read_fin");
    repeat (5) @(negedge clk);

    // Stale write request for 2 cycles after fin, new address at fin+5.
    push_exp(1, 8'h40, 8'h11);
    push_exp(1, 8'h41, 8'h22);
    issue(1, 0, 8'h40, 8'h11);
    @(negedge clk);
    release_req();
    wait_fin("stale_first_fin");
    issue(1, 0, 8'h40, 8'h11);
    repeat (2) @(negedge clk);
    release_req();
    repeat (2) @(negedge clk);
    chk("stale_no_reissue_cs_n", 32'(cs_n), 32'd1);
    issue(1, 0, 8'h41, 8'h22);
    @(negedge clk);
    release_req();
    chk("stale_new_start_cs_n", 32'(cs_n), 32'd0);
    wait_fin("stale_second_fin");
    repeat (5) @(negedge clk);

    // Inputs change after the latch.
    push_exp(1, 8'h52, 8'h93);
    issue(1, 0, 8'h52, 8'h93);
    @(negedge clk);
    release_req();
    dir_in = 8'hFF; dato_in = 8'h00;
    repeat (12) @(negedge clk);
    dir_in = 8'h0A; dato_in = 8'h55;
    wait_fin("latched_fin");
    repeat (5) @(negedge clk);

    // Transfer command is an ordinary write.
    bus_cycle(1, CMD_XFER_F0, CMD_XFER_F2, "cmd_f0_fin");
    chk("dato_leido_held", 32'(dato_leido), 32'h6C);

    // Reset during the write strobe.
    issue(1, 0, 8'h63, 8'h7E);
    @(negedge clk);
    release_req();
    n = 0;
    while (wr_n && n < 40) begin @(negedge clk); n++; end
    chk("reset_test_strobe_reached", 32'(wr_n), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("midreset_wr_n", 32'(wr_n), 32'd1);
    chk("midreset_cs_n", 32'(cs_n), 32'd1);
    chk("midreset_ad_n", 32'(ad_n), 32'd1);
    chk("midreset_ad_oe", 32'(ad_oe), 32'd0);
    chk("midreset_ad_out", 32'(ad_out), 32'd0);
    chk("midreset_fin", 32'(fin), 32'd0);
    chk("midreset_dato_leido", 32'(dato_leido), 32'd0);
    @(negedge clk);
    reset = 0;
    repeat (40) @(negedge clk);

    // Normal operation after the interrupted cycle.
    bus_cycle(1, 8'h0F, 8'hC3, "after_reset_fin");

    chk("expected_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rtc_bus_driver.md
# rtc_bus_driver

Physical bus stage for the real-time-clock chip's multiplexed address/data interface (CS#, A/D#, RD#, WR#, AD[7:0]). It sits directly downstream of the RTC write sequencer, which supplies `escribe`/`activa`/`dir_in`/`dato_in` and waits for `fin`. It also serves the read sequencer's `lee` request. Each request becomes one timed bus cycle: an address phase followed by a data phase. Completion is reported with a one-cycle `fin` pulse.

## Interface
- `T_PULSE`, default 10: length of the A/D# low and RD#/WR# low pulses, in clk cycles (legal range 1..255).
- `T_HOLD`, default 2: hold after the address latch and after the strobe, in cycles (1..255).
- `T_SETUP`, default 2: data setup before WR#, and bus turnaround before RD#, in cycles (1..255).
- `T_REC`, default 4: recovery after `fin` during which requests are ignored (3..255).
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `escribe`  in  1  write request from the write sequencer.
- `activa`  in  1  bus grant qualifier from the write sequencer; a write needs `escribe && activa`.
- `dir_in`  in  8  register address.
- `dato_in`  in  8  write data.
- `lee`  in  1  read request from the read sequencer (address taken from `dir_in`).
- `ad_in`  in  8  AD pins, input side.
- `fin`  out  1  one-cycle completion pulse, shared by reads and writes.
- `dato_leido`  out  8  last read data; holds until the next read completes.
- `cs_n`, `ad_n`, `rd_n`, `wr_n`  out  1  active-low bus strobes.
- `ad_out`  out  8  AD pins, output side.
- `ad_oe`  out  1  AD output enable; 1 means this block drives the AD pins.

## Operation
- All outputs are registered.
- Reset values: `cs_n`, `ad_n`, `rd_n` and `wr_n` are 1; `ad_oe`, `fin`, `ad_out` and `dato_leido` are 0. The state is IDLE.
- A reset asserted mid-cycle returns every output to its reset value on the same edge. No partial strobe may persist.
- States:
  - IDLE
  - ADDR
  - ADDR_HOLD
  - DATA_SETUP (write) / TURN (read)
  - STROBE
  - DATA_HOLD
  - DONE
  - REC
- IDLE: at each edge, if `escribe && activa`, latch `dir_in` and `dato_in`, set the op to write, and go to ADDR. Otherwise, if `lee`, latch `dir_in`, set the op to read, and go to ADDR. Write wins when both are asserted.
- Latched values are used for the whole cycle. Input changes after the latch are ignored.
- ADDR (`T_PULSE` cycles): `cs_n`=0, `ad_n`=0, `ad_oe`=1, `ad_out`=address.
- ADDR_HOLD (`T_HOLD` cycles): `ad_n`=1, address still driven.
- DATA_SETUP, write only (`T_SETUP` cycles): `ad_out`=data, `ad_oe`=1.
- TURN, read only (`T_SETUP` cycles): `ad_oe`=0, `ad_out`=0.
- STROBE (`T_PULSE` cycles):
  - Write: `wr_n`=0.
  - Read: `rd_n`=0; `ad_in` is captured into `dato_leido` on the edge that leaves STROBE.
- DATA_HOLD (`T_HOLD` cycles): strobes high, `cs_n`=0, write data still driven.
- DONE (1 cycle): `fin`=1; `cs_n`=1; `ad_oe`=0; `ad_out`=0.
- REC (`T_REC` cycles): all signals idle. `escribe`, `activa` and `lee` are ignored. Then go to IDLE.
  - The write sequencer keeps `escribe` high with the stale address for up to 2 cycles after `fin`. `T_REC` ≥ 3 guarantees no stale re-issue.
- A phase counter is loaded with T−1 on phase entry and the state advances when it reaches 0.
  - The counter is 8 bits wide.
  - A parameter value of 0 is illegal; simulation must check for it and `$error`.

## Timing
- Request sampled at IDLE edge k: the bus signals take ADDR values at edge k.
- `fin` is high for the single cycle beginning at edge k + 2·`T_PULSE` + 2·`T_HOLD` + `T_SETUP`. With defaults this is k+26.
- IDLE is re-entered at edge k + 27 + `T_REC` (defaults: k+31). A new request can be sampled on that edge.
- `cs_n` is low continuously from edge k until the DONE edge.
- `ad_n` and `rd_n`/`wr_n` are never low simultaneously.
- `ad_oe` is 0 for at least `T_SETUP` cycles before `rd_n` falls.
- The 0xF0/0xF2 transfer commands issued by the write sequencer are ordinary writes with no special handling here.

## Structure
- Shared package `rtc_pkg` holds:
  - state encodings;
  - default timing constants;
  - the RTC bus command codes 0xF0 and 0xF2, also used by the sequencers.
- One natural sub-module, `rtc_phase_timer`: a loadable 8-bit down-counter with a `load` input, a `value` input and a `zero` output.

## Test plan
- Reset, then write `dir_in`=0x21, `dato_in`=0x59 with `escribe`=`activa`=1:
  - `ad_n` low for 10 cycles with `ad_out`=0x21;
  - `wr_n` low for 10 cycles with `ad_out`=0x59;
  - `fin` pulses at request+26.
- Read `dir_in`=0x24 with `ad_in`=0x17 during the strobe: `ad_oe`=0 at least 2 cycles before `rd_n` falls; `dato_leido`=0x17 when `fin` is high.
- `escribe`, `activa` and `lee` asserted together: a write cycle occurs; `lee` is served only after REC.
- `escribe` held high with the stale address for 2 cycles after `fin`: no second bus cycle starts; a new address presented at fin+5 is issued.
- `dir_in` changed mid-cycle: the bus still carries the latched address and data.
- Reset pulsed during STROBE: on the next edge `wr_n`, `cs_n` and `ad_n` are 1, `ad_oe`=0, and no `fin` is produced.
